serial_sub4: RTL and testbench

SERIAL_SUB4 -- requirements
Module: serial_sub4

---
 rtl/serial_sub4_pkg.sv | 22 ++
 rtl/serial_sub4_fs1.sv | 23 ++
 rtl/serial_sub4.sv | 164 ++++++++++++++++
 tb/tb_serial_sub4.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub4_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub4_pkg
// Shared constants and types for the bit-serial 4-bit subtractor.
//   DATA_W   : operand / result width (4)
//   IDX_W    : width of the bit index counter (2)
//   IDX_LAST : index of the final (MSB) bit processed in RUN
//   state_t  : FSM state encoding (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package serial_sub4_pkg;

    localparam int DATA_W = 4;
    localparam int IDX_W  = 2;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub4_fs1.sv
// ---------------------------------------------------------------------------
// fs1
// Combinational 1-bit full subtractor: computes x - y - bin.
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// ---------------------------------------------------------------------------
module fs1 (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub4.sv
// ---------------------------------------------------------------------------
// serial_sub4
// Bit-serial 4-bit subtractor. On start (in IDLE) the operands are latched,
// then one bit per cycle is run LSB-first through a single fs1 instance.
// The full result is published only when the last bit completes, so the
// outputs never show a partially computed value.
//
// Optional feature: define SERIAL_SUB4_OVF_EN to add the signed overflow
// output ovf and its register.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   start : request pulse, sampled only in IDLE
//   a     : minuend (4 bits)
//   b     : subtrahend (4 bits)
//   bin   : borrow in
//   busy  : high in RUN and DONE
//   done  : one-cycle completion pulse (the DONE state)
//   diff  : a - b - bin modulo 16
//   bout  : borrow out (a < b + bin, unsigned)
//   ovf   : signed overflow (only with SERIAL_SUB4_OVF_EN)
// Timing: start sampled at edge k -> done high after edge k+4 -> IDLE after
// edge k+5. With start held high a new operation begins every 6 cycles.
// ---------------------------------------------------------------------------
module serial_sub4
    import serial_sub4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bin,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] diff,
    output logic              bout
`ifdef SERIAL_SUB4_OVF_EN
    ,
    output logic              ovf
`endif
);

    state_t state_reg;
    state_t state_next;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              br_reg;
    logic [IDX_W-1:0]  idx_reg;
    // Difference bits produced so far; the newest bit enters at the top so
    // that after the last bit {d_bit, acc_reg} is the complete result.
    logic [DATA_W-2:0] acc_reg;

    logic [DATA_W-1:0] diff_reg;
    logic              bout_reg;
`ifdef SERIAL_SUB4_OVF_EN
    logic              ovf_reg;
`endif

    logic d_bit;
    logic br_bit;
    logic last_bit;

    // Single subtractor cell, reused for every bit position.
    fs1 u_fs1 (
        .x    (a_reg[idx_reg]),
        .y    (b_reg[idx_reg]),
        .bin  (br_reg),
        .d    (d_bit),
        .bout (br_bit)
    );

    assign last_bit = (state_reg == RUN) && (idx_reg == IDX_LAST);

    // Next-state and status outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx_reg == IDX_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture and serial datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            br_reg  <= 1'b0;
            idx_reg <= '0;
            acc_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (start) begin
                a_reg   <= a;
                b_reg   <= b;
                br_reg  <= bin;
                idx_reg <= '0;
                acc_reg <= '0;
            end
        end else if (state_reg == RUN) begin
            acc_reg <= {d_bit, acc_reg[DATA_W-2:1]};
            br_reg  <= br_bit;
            idx_reg <= idx_reg + IDX_W'(1);
        end
    end

    // Result registers: updated only on the RUN->DONE edge and held
    // until the next completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_reg <= '0;
            bout_reg <= 1'b0;
        end else if (last_bit) begin
            diff_reg <= {d_bit, acc_reg};
            bout_reg <= br_bit;
        end
    end

`ifdef SERIAL_SUB4_OVF_EN
    // Overflow when operand signs differ and the result sign differs from a.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (last_bit) begin
            ovf_reg <= (a_reg[DATA_W-1] ^ b_reg[DATA_W-1]) & (a_reg[DATA_W-1] ^ d_bit);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_sub4.sv
// ---------------------------------------------------------------------------
// tb_serial_sub4
// Directed testbench for serial_sub4. Each scenario is a task with its own
// inline comparisons; a summary line is printed at the end.
// Define SERIAL_SUB4_OVF_EN to also check the overflow output.
// ---------------------------------------------------------------------------
module tb_serial_sub4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;
`ifdef SERIAL_SUB4_OVF_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_sub4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB4_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Directed vectors: a, b, bin -> diff, bout, ovf (hand computed).
    logic [3:0] va   [7] = '{4'h9, 4'h3, 4'h0, 4'h7, 4'h5, 4'h0, 4'hF};
    logic [3:0] vb   [7] = '{4'h3, 4'h9, 4'h0, 4'hF, 4'h2, 4'hF, 4'h0};
    logic       vbin [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] vd   [7] = '{4'h6, 4'hA, 4'hF, 4'h8, 4'h3, 4'h0, 4'hF};
    logic       vbo  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       vov  [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Stimulus only: issues one start pulse and returns the number of
    // negedges after the start-clearing negedge until done (-1 on timeout).
    task automatic do_op(input logic [3:0] ta, input logic [3:0] tb_v,
                         input logic tbin, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; a = 4'h9; b = 4'h3; bin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_status: busy/done got %b expected 00", {busy, done});
        end
        checks++;
        if ({diff, bout} !== 5'b0) begin
            failures++;
            $display("FAIL reset_result: diff/bout got %h expected 00", {diff, bout});
        end
`ifdef SERIAL_SUB4_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %b expected 0", ovf);
        end
`endif
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored: busy got %b expected 0", busy);
        end
        $display("reset: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
    endtask

    task automatic test_vectors();
        int lat;
        for (int v = 0; v < 7; v++) begin
            do_op(va[v], vb[v], vbin[v], lat);
            checks++;
            if (lat !== 4) begin
                failures++;
                $display("FAIL vec%0d_latency: got %0d expected 4", v, lat);
            end
            checks++;
            if (diff !== vd[v]) begin
                failures++;
                $display("FAIL vec%0d_diff: got %h expected %h", v, diff, vd[v]);
            end
            checks++;
            if (bout !== vbo[v]) begin
                failures++;
                $display("FAIL vec%0d_bout: got %b expected %b", v, bout, vbo[v]);
            end
`ifdef SERIAL_SUB4_OVF_EN
            checks++;
            if (ovf !== vov[v]) begin
                failures++;
                $display("FAIL vec%0d_ovf: got %b expected %b", v, ovf, vov[v]);
            end
`endif
            $display("op a=%h b=%h bin=%b -> diff=%h bout=%b lat=%0d",
                     va[v], vb[v], vbin[v], diff, bout, lat);
            // done is a single-cycle pulse and the block returns to IDLE.
            @(negedge clk);
            checks++;
            if ({done, busy} !== 2'b00) begin
                failures++;
                $display("FAIL vec%0d_pulse: done/busy got %b expected 00", v, {done, busy});
            end
            // Result holds while idle, even with new operands on the inputs.
            a = ~va[v]; b = ~vb[v];
            repeat (2) @(negedge clk);
            checks++;
            if ({diff, bout} !== {vd[v], vbo[v]}) begin
                failures++;
                $display("FAIL vec%0d_hold: got %h expected %h", v, {diff, bout}, {vd[v], vbo[v]});
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        @(negedge clk);
        a = 4'h6; b = 4'h1; bin = 1'b0; start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (n == 1) begin
                a = 4'hF; b = 4'hF; bin = 1'b1;
            end
            start = (n == 2 || n == 4);
        end
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL ignore_start_pulses: got %0d done pulses expected 1", ndone);
        end
        checks++;
        if ({diff, bout} !== {4'h5, 1'b0}) begin
            failures++;
            $display("FAIL ignore_start_result: got %h expected %h", {diff, bout}, {4'h5, 1'b0});
        end
        $display("op a=6 b=1 bin=0 (start pulses + operand change mid-run) -> diff=%h bout=%b pulses=%0d",
                 diff, bout, ndone);
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        int lat;
        @(negedge clk);
        a = 4'h9; b = 4'h3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, diff, bout} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid_state: busy/done/diff/bout got %b expected 0000000",
                     {busy, done, diff, bout});
        end
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", ndone);
        end
        do_op(4'h9, 4'h3, 1'b0, lat);
        checks++;
        if ({lat == 4, diff, bout} !== {1'b1, 4'h6, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_restart: lat=%0d diff=%h bout=%b expected lat=4 diff=6 bout=0",
                     lat, diff, bout);
        end
        $display("reset mid-run then a=9 b=3 bin=0 -> diff=%h bout=%b lat=%0d", diff, bout, lat);
    endtask

    task automatic test_back_to_back();
        logic [8:0] v;
        logic [8:0] vn;
        logic [4:0] t;
        int         cnt;
        int         sd;
        logic       got;
        logic       exp_ovf;
        v = 9'd0;
        @(negedge clk);
        a = v[8:5]; b = v[4:1]; bin = v[0]; start = 1'b1;
        for (int i = 0; i < 512; i++) begin
            v = 9'(i);
            got = 1'b0;
            cnt = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    got = 1'b1;
                    cnt = c;
                    break;
                end
            end
            if (!got) begin
                checks++;
                failures++;
                $display("FAIL b2b_timeout: op %0d no done within 12 cycles", i);
                break;
            end
            if (i > 0) begin
                checks++;
                if (cnt !== 6) begin
                    failures++;
                    $display("FAIL b2b_period op%0d: got %0d cycles expected 6", i, cnt);
                end
            end
            t = 5'd16 + {1'b0, v[8:5]} - {1'b0, v[4:1]} - {4'd0, v[0]};
            checks++;
            if ({diff, bout} !== {t[3:0], ~t[4]}) begin
                failures++;
                $display("FAIL b2b_result a=%h b=%h bin=%b: got diff=%h bout=%b expected diff=%h bout=%b",
                         v[8:5], v[4:1], v[0], diff, bout, t[3:0], ~t[4]);
            end
            sd = int'($signed(v[8:5])) - int'($signed(v[4:1])) - int'(v[0]);
            exp_ovf = (sd < -8) || (sd > 7);
`ifdef SERIAL_SUB4_OVF_EN
            checks++;
            if (ovf !== exp_ovf) begin
                failures++;
                $display("FAIL b2b_ovf a=%h b=%h bin=%b: got %b expected %b",
                         v[8:5], v[4:1], v[0], ovf, exp_ovf);
            end
`endif
            $display("op a=%h b=%h bin=%b -> diff=%h bout=%b ovf_model=%b period=%0d",
                     v[8:5], v[4:1], v[0], diff, bout, exp_ovf, cnt);
            vn = 9'(i + 1);
            a = vn[8:5]; b = vn[4:1]; bin = vn[0];
            if (i == 511) start = 1'b0;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = 4'h0; b = 4'h0; bin = 1'b0;
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
